// File: rtl/async_fifo_pkg.sv
// Purpose : shared types, defaults and Gray/binary helpers for both sides of the two-clock FIFO.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package async_fifo_pkg;

   localparam int ASYNC_FIFO_DW = 32;
   localparam int ASYNC_FIFO_AW = 4;

   // Helpers work on a fixed wide vector; callers zero-extend and truncate
   // to their pointer width. Zero upper bits do not disturb the low bits.
   localparam int PTR_MAX_W = 32;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_HOLD = 1'b1
   } rd_state_e;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = PTR_MAX_W-2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/async_fifo_gray_sync.sv
// Purpose : two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Latency : 2 clk edges from a stable input to q_sync.
// Backpr. : none; free-running every cycle.
// Ports   : clk/rst (async active-high), d_async (foreign-domain Gray value), q_sync (synchronised).
module async_fifo_gray_sync #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_async,
   output logic [W-1:0] q_sync
);

   logic [W-1:0] meta_q, meta_d;
   logic [W-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d_async;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_sync = sync_q;

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Purpose : read side of the two-clock FIFO; syncs the write Gray pointer, derives empty, pops storage.
// Latency : write pointer stable before edge N -> tx_vld after edge N+2; then one word per cycle.
// Backpr. : tx_vld && !tx_rdy freezes tx_data/tx_vld and the read pointer.
// Ports   : rd_clk/rd_rst (async active-high); wr_ptr_grey_async in; rd_ptr_grey out to write side;
//           rd_addr/rd_data to storage (combinational read); tx_vld/tx_data/tx_rdy downstream;
//           rd_level (words in storage, excluding held word) only when ASYNC_FIFO_RD_LEVEL_EN is defined.
module async_fifo_rd_ctrl
   import async_fifo_pkg::*;
#(
   parameter int DW = ASYNC_FIFO_DW,
   parameter int AW = ASYNC_FIFO_AW
) (
   input  logic          rd_clk,
   input  logic          rd_rst,
   input  logic [AW:0]   wr_ptr_grey_async,
   output logic [AW:0]   rd_ptr_grey,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          tx_vld,
   output logic [DW-1:0] tx_data,
   input  logic          tx_rdy
`ifdef ASYNC_FIFO_RD_LEVEL_EN
   ,
   output logic [AW:0]   rd_level
`endif
);

   localparam int PW = AW + 1;

   logic [AW:0]   wr_ptr_grey_sync;
   logic [AW:0]   rd_ptr_bin_q, rd_ptr_bin_d;
   logic [AW:0]   rd_ptr_grey_q, rd_ptr_grey_d;
   logic [DW-1:0] tx_data_q, tx_data_d;
   rd_state_e     state_q, state_d;
   logic          empty;
   logic          fetch;

   async_fifo_gray_sync #(.W(PW)) u_wr_ptr_sync (
      .clk     (rd_clk),
      .rst     (rd_rst),
      .d_async (wr_ptr_grey_async),
      .q_sync  (wr_ptr_grey_sync)
   );

   // Comparing Gray codes directly avoids converting the synced pointer.
   assign empty = (rd_ptr_grey_q == wr_ptr_grey_sync);
   assign fetch = !empty && ((state_q == RD_IDLE) || tx_rdy);

   always_comb begin
      state_d       = state_q;
      tx_data_d     = tx_data_q;
      rd_ptr_bin_d  = rd_ptr_bin_q;
      if (fetch) begin
         tx_data_d    = rd_data;
         rd_ptr_bin_d = rd_ptr_bin_q + 1'b1;
      end
      case (state_q)
         RD_IDLE: if (fetch)            state_d = RD_HOLD;
         RD_HOLD: if (tx_rdy && !fetch) state_d = RD_IDLE;
         default:                       state_d = RD_IDLE;
      endcase
      // Grey is derived from the next binary value so both flops move on the same edge.
      rd_ptr_grey_d = PW'(bin2gray(PTR_MAX_W'(rd_ptr_bin_d)));
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) begin
         state_q       <= RD_IDLE;
         tx_data_q     <= '0;
         rd_ptr_bin_q  <= '0;
         rd_ptr_grey_q <= '0;
      end else begin
         state_q       <= state_d;
         tx_data_q     <= tx_data_d;
         rd_ptr_bin_q  <= rd_ptr_bin_d;
         rd_ptr_grey_q <= rd_ptr_grey_d;
      end
   end

   assign tx_vld      = (state_q == RD_HOLD);
   assign tx_data     = tx_data_q;
   assign rd_ptr_grey = rd_ptr_grey_q;
   assign rd_addr     = rd_ptr_bin_q[AW-1:0];

`ifdef ASYNC_FIFO_RD_LEVEL_EN
   logic [AW:0] wr_bin_sync;
   logic [AW:0] rd_level_q, rd_level_d;

   // Modular subtraction gives 0..2^AW; the word parked in tx_data is already popped.
   always_comb begin
      wr_bin_sync = PW'(gray2bin(PTR_MAX_W'(wr_ptr_grey_sync)));
      rd_level_d  = wr_bin_sync - rd_ptr_bin_q;
   end

   always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) rd_level_q <= '0;
      else        rd_level_q <= rd_level_d;
   end

   assign rd_level = rd_level_q;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Purpose : directed self-checking bench for async_fifo_rd_ctrl with a behavioural storage array.
// Latency : n/a.
// Backpr. : bench drives tx_rdy directly (held, constant, toggling).
module tb_async_fifo_rd_ctrl;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          rd_clk = 1'b0;
   logic          rd_rst;
   logic [AW:0]   wr_ptr_grey_async;
   logic [AW:0]   rd_ptr_grey;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          tx_vld;
   logic [DW-1:0] tx_data;
   logic          tx_rdy;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
   logic [AW:0]   rd_level;
`endif

   logic [DW-1:0] mem [16];

   int checks = 0;
   int errors = 0;

   // Bench-side stream state (absolute counts since last reset).
   int wr_bin;
   int acc;
   int fetch_n;

   always #5 rd_clk = ~rd_clk;

   assign rd_data = mem[rd_addr];

   async_fifo_rd_ctrl #(.DW(DW), .AW(AW)) dut (
      .rd_clk            (rd_clk),
      .rd_rst            (rd_rst),
      .wr_ptr_grey_async (wr_ptr_grey_async),
      .rd_ptr_grey       (rd_ptr_grey),
      .rd_addr           (rd_addr),
      .rd_data           (rd_data),
      .tx_vld            (tx_vld),
      .tx_data           (tx_data),
      .tx_rdy            (tx_rdy)
`ifdef ASYNC_FIFO_RD_LEVEL_EN
      ,
      .rd_level          (rd_level)
`endif
   );

   function automatic logic [4:0] g5(input int b);
      logic [4:0] v;
      v = b[4:0];
      return v ^ (v >> 1);
   endfunction

   function automatic logic [DW-1:0] word(input int p);
      return 32'hD000_0000 + DW'(p);
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge rd_clk);
      #1;
   endtask

   task automatic push_word();
      mem[wr_bin % 16] = word(wr_bin);
      wr_bin++;
      wr_ptr_grey_async = g5(wr_bin);
   endtask

   // Streams until 'target' words accepted; mode 0: tx_rdy=1, mode 1: tx_rdy toggles.
   task automatic run_stream(input int target, input int mode);
      int cyc;
      logic [DW-1:0] held;
      logic stalled;
      logic [4:0] prev_g;
      cyc = 0;
      while (acc < target && cyc < 400) begin
         if (wr_bin < target && (wr_bin - acc) < 16) push_word();
         tx_rdy = (mode == 0) ? 1'b1 : cyc[0];
         stalled = tx_vld && !tx_rdy;
         held = tx_data;
         if (tx_vld && tx_rdy) begin
            chk("stream_data", 64'(tx_data), 64'(word(acc)));
            acc++;
         end
         prev_g = rd_ptr_grey;
         step();
         cyc++;
         if (stalled) begin
            chk("stall_vld", 64'(tx_vld), 64'd1);
            chk("stall_data", 64'(tx_data), 64'(held));
            chk("stall_ptr", 64'(rd_ptr_grey), 64'(prev_g));
         end
         if (rd_ptr_grey != prev_g) begin
            fetch_n++;
            chk("grey_onebit", 64'($countones(rd_ptr_grey ^ prev_g)), 64'd1);
            chk("grey_order", 64'(rd_ptr_grey), 64'(g5(fetch_n)));
         end
      end
      chk("stream_count", 64'(acc), 64'(target));
   endtask

   initial begin
      rd_rst = 1'b1;
      wr_ptr_grey_async = '0;
      tx_rdy = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      #1;
      chk("rst_vld_async", 64'(tx_vld), 64'd0);
      step();
      step();
      rd_rst = 1'b0;

      // Reset state holds with nothing written.
      for (int i = 0; i < 4; i++) begin
         step();
         chk("idle_vld", 64'(tx_vld), 64'd0);
         chk("idle_grey", 64'(rd_ptr_grey), 64'd0);
         chk("idle_addr", 64'(rd_addr), 64'd0);
      end

      // Single word: write pointer 0 -> 1.
      mem[0] = 32'hA5A5_A5A5;
      tx_rdy = 1'b1;
      wr_ptr_grey_async = 5'h01;
      step();
      chk("lat_e1_vld", 64'(tx_vld), 64'd0);
      step();
      chk("lat_e2_vld", 64'(tx_vld), 64'd0);
      step();
      chk("lat_e3_vld", 64'(tx_vld), 64'd1);
      chk("lat_e3_data", 64'(tx_data), 64'hA5A5_A5A5);
      chk("lat_e3_grey", 64'(rd_ptr_grey), 64'd1);
      step();
      chk("lat_e4_vld", 64'(tx_vld), 64'd0);
      chk("lat_e4_grey", 64'(rd_ptr_grey), 64'd1);
      chk("lat_e4_addr", 64'(rd_addr), 64'd1);

      // Full depth: reset, write pointer at 16 (Gray 0x18), hold then drain.
      rd_rst = 1'b1;
      wr_ptr_grey_async = '0;
      tx_rdy = 1'b0;
      step();
      rd_rst = 1'b0;
      step();
      for (int i = 0; i < 16; i++) mem[i] = word(i);
      wr_ptr_grey_async = 5'h18;
      step();
      step();
      step();
      chk("full_first_vld", 64'(tx_vld), 64'd1);
      chk("full_first_data", 64'(tx_data), 64'(word(0)));
      step();
      step();
      chk("full_hold_data", 64'(tx_data), 64'(word(0)));
      chk("full_hold_grey", 64'(rd_ptr_grey), 64'h01);
      tx_rdy = 1'b1;
      for (int k = 1; k < 16; k++) begin
         step();
         chk("full_drain_vld", 64'(tx_vld), 64'd1);
         chk("full_drain_data", 64'(tx_data), 64'(word(k)));
      end
      step();
      chk("full_empty_vld", 64'(tx_vld), 64'd0);
      chk("full_empty_grey", 64'(rd_ptr_grey), 64'h18);

      // 40 more words across the 31 -> 0 wrap.
      wr_bin = 16;
      acc = 16;
      fetch_n = 16;
      run_stream(56, 0);

      // 5 words with tx_rdy toggling every cycle.
      run_stream(61, 1);
      tx_rdy = 1'b1;
      for (int i = 0; i < 4; i++) step();
      chk("toggle_no_dup_vld", 64'(tx_vld), 64'd0);
      chk("toggle_final_grey", 64'(rd_ptr_grey), 64'(g5(61)));

      // Reset while holding with 3 words pending.
      tx_rdy = 1'b0;
      for (int i = 0; i < 3; i++) push_word();
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_vld", 64'(tx_vld), 64'd1);
      chk("pre_rst_data", 64'(tx_data), 64'(word(61)));
      #2;
      rd_rst = 1'b1;
      #1;
      chk("mid_rst_vld", 64'(tx_vld), 64'd0);
      chk("mid_rst_grey", 64'(rd_ptr_grey), 64'd0);
      chk("mid_rst_addr", 64'(rd_addr), 64'd0);
      chk("mid_rst_data", 64'(tx_data), 64'd0);
      wr_ptr_grey_async = '0;
      step();
      rd_rst = 1'b0;
      step();
      step();
      step();
      chk("post_rst_vld", 64'(tx_vld), 64'd0);
      chk("post_rst_grey", 64'(rd_ptr_grey), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
